// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin grant scheduler.
// Includes the state encoding and the index-to-one-hot helper.
package arb_pkg;

    localparam int N_REQ           = 4;
    localparam int IDX_W           = 2;
    localparam int TIMEOUT_CYC_DEF = 15;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
// It rotates the request vector by ptr, priority-encodes it, and then un-rotates the result.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] sel_idx_o,
    output logic             any_req_o
);

    logic [N_REQ-1:0] rot_s;
    logic [IDX_W-1:0] enc_s;
    logic [IDX_W-1:0] src_s;

    // Rotate so that the requester at ptr lands in bit 0 (2-bit index wraps naturally).
    always_comb begin
        rot_s = 4'b0000;
        src_s = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            src_s    = IDX_W'(i) + ptr_i;
            rot_s[i] = req_i[src_s];
        end
    end

    // Lowest set bit wins inside the rotated frame.
    always_comb begin
        casez (rot_s)
            4'b???1: enc_s = 2'd0;
            4'b??10: enc_s = 2'd1;
            4'b?100: enc_s = 2'd2;
            4'b1000: enc_s = 2'd3;
            default: enc_s = 2'd0;
        endcase
    end

    assign sel_idx_o = enc_s + ptr_i;
    assign any_req_o = |req_i;

endmodule

// File: rtl/rr_grant_scheduler.sv
// Non-preemptive 4-way round-robin arbiter. A grant is held until done is asserted.
// Define ARB_TIMEOUT_EN to add a hold counter that forces release and pulses timeout.
module rr_grant_scheduler
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic             gnt_valid_q;
    logic [IDX_W-1:0] sel_idx_s;
    logic             any_req_s;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]       hold_cnt_q;
    logic             timeout_q;
`endif

    rr_pick4 u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .sel_idx_o (sel_idx_s),
        .any_req_o (any_req_s)
    );

    // Arbiter FSM with its pointer, output registers and optional hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (any_req_s) begin
                        gnt_q       <= idx_to_onehot(sel_idx_s);
                        gnt_idx_q   <= sel_idx_s;
                        gnt_valid_q <= 1'b1;
                        state_q     <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q  <= 8'd0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    // done has priority over the timeout, so timeout is not pulsed when both occur.
                    if (done) begin
                        gnt_q       <= 4'b0000;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_idx_q + 2'd1;
                        state_q     <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                        gnt_q       <= 4'b0000;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_idx_q + 2'd1;
                        state_q     <= IDLE;
                        timeout_q   <= 1'b1;
                    end else begin
                        hold_cnt_q  <= hold_cnt_q + 8'd1;
                    end
`else
                    end else begin
                        state_q <= GRANT;
                    end
`endif
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= 4'b0000;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed self-checking bench for rr_grant_scheduler.
// The timeout checks are compiled only when ARB_TIMEOUT_EN is defined.
module tb_rr_grant_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rr_grant_scheduler #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        chk({tag, "_gnt"}, {4'd0, gnt}, {4'd0, oh});
        chk({tag, "_idx"}, {6'd0, gnt_idx}, {6'd0, idx});
        chk({tag, "_vld"}, {7'd0, gnt_valid}, 8'd1);
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] idx);
        chk({tag, "_gnt"}, {4'd0, gnt}, 8'd0);
        chk({tag, "_idx"}, {6'd0, gnt_idx}, {6'd0, idx});
        chk({tag, "_vld"}, {7'd0, gnt_valid}, 8'd0);
    endtask

    initial begin
        logic [1:0] rot_exp [5];
        rot_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        #2;
        chk_idle("reset", 2'd0);
        step();
        step();
        rst = 1'b0;

        // Single requester
        req = 4'b0010;
        step();
        chk_grant("single", 2'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_grant("single_hold", 2'd1);
        end
        done = 1'b1;
        step();
        chk_idle("single_rel", 2'd1);
        done = 1'b0;
        // ptr is now 2: 0110 picks 2, not 1
        req = 4'b0110;
        step();
        chk_grant("ptr2", 2'd2);
        done = 1'b1;
        step();
        done = 1'b0;

        // Wrap and skip from ptr=3
        req = 4'b0101;
        step();
        chk_grant("wrap", 2'd0);
        done = 1'b1;
        step();
        chk_idle("wrap_rel", 2'd0);
        done = 1'b0;
        step();
        chk_grant("skip", 2'd2);
        done = 1'b1;
        step();
        done = 1'b0;

        // Withdrawal (ptr=3)
        req = 4'b0010;
        step();
        chk_grant("wd", 2'd1);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_grant("wd_hold", 2'd1);
        end
        done = 1'b1;
        step();
        chk_idle("wd_rel", 2'd1);
        step();
        step();
        chk_idle("stray_done", 2'd1);
        done = 1'b0;

        // Reset mid-grant (ptr=2)
        req = 4'b0100;
        step();
        chk_grant("pre_rst", 2'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("mid_rst", 2'd0);
        #1;
        rst = 1'b0;
        step();
        chk_grant("post_rst", 2'd2);
        done = 1'b1;
        step();
        done = 1'b0;

        // Reset again so that rotation starts from ptr=0
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_grant("rot", rot_exp[i]);
            done = 1'b1;
            step();
            chk_idle("rot_gap", rot_exp[i]);
            done = 1'b0;
        end
        req = 4'b0000;
        step();

`ifdef ARB_TIMEOUT_EN
        // Forced release after 4 GRANT cycles (ptr=1)
        req = 4'b1000;
        step();
        chk_grant("to", 2'd3);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_grant("to_hold", 2'd3);
            chk("to_pulse_early", {7'd0, timeout}, 8'd0);
        end
        step();
        chk_idle("to_rel", 2'd3);
        chk("to_pulse", {7'd0, timeout}, 8'd1);
        step();
        chk("to_pulse_end", {7'd0, timeout}, 8'd0);
        req = 4'b1001;
        step();
        chk_grant("to_ptr0", 2'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        // done coincides with the limit (ptr=1)
        req = 4'b1000;
        step();
        chk_grant("to2", 2'd3);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk_idle("to2_rel", 2'd3);
        chk("to2_nopulse", {7'd0, timeout}, 8'd0);
        req = 4'b1001;
        step();
        chk_grant("to2_ptr0", 2'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin arbiter that shares a single downstream resource between 4 requesters.
- Each grant is held until the resource signals completion, so access is fair and non-preemptive.
- Uses a 4-to-2 encoding of the one-hot grant, so consumers get both `gnt` (one-hot) and `gnt_idx` (binary).
- Sits between the requester channels and the shared datapath. `gnt_idx` drives the datapath input mux select.

Parameters:
- N_REQ, 4, number of requesters. Fixed at 4 for this revision; other values are unsupported.
- IDX_W, 2, width of `gnt_idx`. Must equal clog2(N_REQ).
- TIMEOUT_CYC, 15, maximum cycles a grant may be held. Used only when the optional feature is compiled in. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  4  request vector; bit i = requester i.
- done  input  1  resource has finished the current transaction. Sampled only in GRANT.
- gnt  output  4  one-hot grant, registered.
- gnt_idx  output  2  binary index of the granted requester, registered.
- gnt_valid  output  1  high while any grant is active, registered.
- timeout  output  1  one-cycle pulse on a forced release. Present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1) puts the block in a known state immediately, regardless of state:
  - state = IDLE, ptr = 0.
  - gnt = 4'b0000, gnt_idx = 2'd0, gnt_valid = 0, timeout = 0.
- State machine: IDLE, GRANT.
- IDLE:
  - If req == 0: remain in IDLE; outputs stay 0.
  - Otherwise, select the first set bit of req, searching cyclically from ptr upward: ptr, ptr+1, ..., wrapping 3→0.
  - On the next edge: gnt = onehot(sel), gnt_idx = sel, gnt_valid = 1, state → GRANT.
  - Grant latency is 1 cycle from req being sampled in IDLE.
- GRANT:
  - gnt, gnt_idx and gnt_valid hold constant.
  - If the granted requester drops its req bit, the grant is still held. done is authoritative.
  - New req bits are ignored (no preemption).
- done=1 sampled in GRANT:
  - On the next edge: gnt = 0, gnt_valid = 0, gnt_idx keeps its last value.
  - ptr = (gnt_idx + 1) mod 4, wrapping 3→0.
  - state → IDLE.
- Inter-grant gap: there is always at least one IDLE cycle between grants. Maximum throughput is 1 grant per 2 cycles when done arrives on the first GRANT cycle.
- done=1 in IDLE is ignored.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - When gnt_valid = 1, gnt == (1 << gnt_idx).
- Starvation bound: a requester holding req high is granted within 3 other grants.
- All outputs are registered with no combinational path from inputs. req and done are synchronous to clk.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Adds an 8-bit hold counter, cleared on entry to GRANT and incremented each GRANT cycle without done.
  - When the counter reaches TIMEOUT_CYC - 1 with done=0, the next edge performs the same release as done (same ptr update), and timeout pulses 1 for exactly that one cycle.
  - If done and the timeout limit coincide, done wins and timeout stays 0.
  - The timeout port exists.
- Undefined: no counter and no timeout port. A grant is held indefinitely until done.

Decomposition:
- Shared package `arb_pkg` holds:
  - state typedef {IDLE, GRANT}.
  - constants N_REQ=4, IDX_W=2.
  - default TIMEOUT_CYC.
- Sub-module `rr_pick4`: purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: sel_idx[1:0], any_req.
  - Implemented as rotate, then 4-to-2 priority encode, then un-rotate.
  - Unit-testable on its own against a behavioural golden model with random vectors.
- The top level holds the FSM, ptr, output registers and the optional counter.

Test Plan:
- Reset mid-grant: grant requester 2, assert rst asynchronously between edges → gnt=0000, gnt_valid=0, gnt_idx=0 immediately. After release, req=0100 → gnt_idx=2 (ptr restarted at 0, so index 2 is chosen again).
- Single requester: req=0010 from reset → next edge gnt=0010, gnt_idx=1, gnt_valid=1. Hold 5 cycles. done=1 → next edge gnt=0000, ptr=2.
- All request, rotation: req=1111 held, done pulsed 1 cycle after each grant → grant sequence idx 0,1,2,3,0, with exactly one IDLE cycle between grants.
- Wrap and skip: ptr=3, req=0101 → gnt_idx=0. After done, ptr=1, same req → gnt_idx=2.
- Request withdrawal and stray done: grant idx 1, drop req to 0000 → gnt held until done. done=1 in IDLE with req=0 → no output change.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=4:
  - Grant idx 3 with done held 0 → release after 4 GRANT cycles, timeout=1 for one cycle, ptr=0.
  - Repeat with done=1 on the 4th cycle → release, timeout stays 0.
